// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the nibble-serial adder
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  // Number of slice passes needed for an operand of the given width
  function automatic int nibble_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/fourbit_FA_str.sv
// rtl/fourbit_FA_str.sv - structural 4-bit ripple-carry adder slice
module fourbit_FA_str (
  output logic       Cout,
  output logic [3:0] S,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin
);

  wire [4:0] c;
  wire [3:0] p;
  wire [3:0] g;
  wire [3:0] t;

  assign c[0] = Cin;

  // One gate-level full adder per bit, carry rippling upward
  genvar i;
  generate
    for (i = 0; i < 4; i = i + 1) begin : g_bit
      xor u_p   (p[i], A[i], B[i]);
      xor u_s   (S[i], p[i], c[i]);
      and u_g   (g[i], A[i], B[i]);
      and u_t   (t[i], p[i], c[i]);
      or  u_c   (c[i+1], g[i], t[i]);
    end
  endgenerate

  assign Cout = c[4];

endmodule

// File: rtl/serial_add16.sv
// rtl/serial_add16.sv - multi-cycle adder, one nibble per clock through a 4-bit slice
module serial_add16
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = nibble_count(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
      $error("serial_add16: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             c_r;
  logic [IDX_W-1:0] idx;

  logic [NIB_W-1:0] nib_s;
  logic             nib_cout;
  logic [WIDTH-1:0] acc_next;
  logic             ovf_last;

  fourbit_FA_str u_slice (
    .Cout (nib_cout),
    .S    (nib_s),
    .A    (a_sh[NIB_W-1:0]),
    .B    (b_sh[NIB_W-1:0]),
    .Cin  (c_r)
  );

  // New nibble enters at the top so that after the last pass acc holds the full sum
  assign acc_next = (acc >> NIB_W) | (WIDTH'(nib_s) << (WIDTH - NIB_W));

  // On the last pass the slice sees the operand MSBs; signed overflow when
  // like-signed operands produce a differently-signed result
  assign ovf_last = (a_sh[NIB_W-1] == b_sh[NIB_W-1]) && (nib_s[NIB_W-1] != a_sh[NIB_W-1]);

  // Control FSM and datapath registers; outputs are registered and only the
  // completion edge updates sum/cout/ovf
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      c_r   <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c_r   <= cin;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_sh >> NIB_W;
          b_sh <= b_sh >> NIB_W;
          acc  <= acc_next;
          c_r  <= nib_cout;
          idx  <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            sum   <= acc_next;
            cout  <= nib_cout;
            ovf   <= ovf_last;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add16.sv
// tb/tb_serial_add16.sv - self-checking bench for serial_add16
module tb_serial_add16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_assert;
  int n_fail;

  logic [15:0] exp_sum;
  logic        exp_cout;
  logic        exp_ovf;

  serial_add16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on the whole operands
  task automatic model(input logic [15:0] x, input logic [15:0] y, input logic c);
    longint unsigned tot;
    int s;
    tot      = longint'(x) + longint'(y) + longint'(c);
    exp_sum  = tot[15:0];
    exp_cout = tot[16];
    s        = int'($signed(x)) + int'($signed(y)) + int'(c);
    exp_ovf  = (s > 32767) || (s < -32768);
  endtask

  // Called at a negedge; returns at the negedge just after the accepting edge
  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic c);
    model(x, y, c);
    start = 1'b1;
    a     = x;
    b     = y;
    cin   = c;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    cin   = 1'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Waits for done (bounded), optionally scrambling inputs during RUN, then
  // checks latency and results; returns at the negedge of the DONE cycle
  task automatic finish_op(input bit noisy);
    int lat;
    lat = 0;
    while (!done && lat < 20) begin
      if (noisy) begin
        start = 1'($urandom);
        a     = 16'($urandom);
        b     = 16'($urandom);
        cin   = 1'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    check("latency", lat, 32'd4);
    check("done", {31'd0, done}, 32'd1);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("sum", {16'd0, sum}, {16'd0, exp_sum});
    check("cout", {31'd0, cout}, {31'd0, exp_cout});
    check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  // One idle cycle after DONE: pulse must drop, result must hold
  task automatic idle_step();
    @(posedge clk);
    @(negedge clk);
    check("done_pulse_one_cycle", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("sum_hold", {16'd0, sum}, {16'd0, exp_sum});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst   = 1'b1;
    start = 1'b1;
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    cin   = 1'b1;

    // Reset held with start asserted: nothing may move
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_after_rst", {31'd0, busy}, 32'd0);

    // Directed cases
    start_op(16'h00FF, 16'h0001, 1'b0);
    finish_op(1'b0);
    check("dir_00ff_sum", {16'd0, sum}, 32'h0100);
    idle_step();

    start_op(16'hFFFF, 16'hFFFF, 1'b1);
    finish_op(1'b0);
    check("dir_ffff_sum", {16'd0, sum}, 32'hFFFF);
    check("dir_ffff_cout", {31'd0, cout}, 32'd1);
    idle_step();

    start_op(16'h7FFF, 16'h0001, 1'b0);
    finish_op(1'b0);
    check("dir_7fff_sum", {16'd0, sum}, 32'h8000);
    check("dir_7fff_ovf", {31'd0, ovf}, 32'd1);
    idle_step();

    // Ignored inputs during RUN, then back-to-back start in the DONE cycle
    start_op(16'($urandom), 16'($urandom), 1'($urandom));
    finish_op(1'b1);
    start_op(16'h1234, 16'h4321, 1'b0);
    finish_op(1'b0);
    check("b2b_sum", {16'd0, sum}, 32'h5555);
    idle_step();

    // Reset during the second RUN cycle
    start_op(16'hBEEF, 16'h1357, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_sum", {16'd0, sum}, 32'd0);
    check("midrst_cout", {31'd0, cout}, 32'd0);
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("midrst_no_done", {31'd0, done}, 32'd0);
    end
    start_op(16'h0A0A, 16'h0505, 1'b0);
    finish_op(1'b0);
    check("post_rst_sum", {16'd0, sum}, 32'h0F0F);
    idle_step();

    // Random operands, mixing idle gaps, back-to-back starts and noisy RUN inputs
    for (int i = 0; i < 24; i++) begin
      start_op(16'($urandom), 16'($urandom), 1'($urandom));
      finish_op(1'(i % 2));
      if (i % 3 == 0) idle_step();
    end
    idle_step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
